// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared definitions for the sram-backed FIFO controller.
// Default widths and FSM state encodings.
package sram_fifo_ctrl_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_ADDR_W = 8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } fifo_state_t;

endpackage

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller on a single-port sram, one access per cycle.
// The head word sits in a registered output stage ahead of the sram.
module sram_fifo_ctrl
    import sram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int CNT_W = ADDR_W + 1;

    fifo_state_t       state_q;
    fifo_state_t       state_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  mem_cnt;
    logic              out_vld;
    logic [DATA_W-1:0] rd_data_q;
    logic              init_q;
    logic              rd_issue;
    logic              push;
    logic              pop;
    logic              not_full;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
    endfunction

    assign not_full = (mem_cnt != CNT_W'(DEPTH));
    assign rd_valid = out_vld;
    assign rd_data  = rd_data_q;
    assign count    = mem_cnt + {{ADDR_W{1'b0}}, out_vld};

    // Arbitrate the sram port: a refill read wins, otherwise accept a push.
    always_comb begin
        state_d   = state_q;
        rd_issue  = 1'b0;
        wr_ready  = 1'b0;
        push      = 1'b0;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        pop       = out_vld && rd_ready;
        unique case (state_q)
            ST_IDLE: begin
                if ((mem_cnt != '0) && (!out_vld || pop)) begin
                    rd_issue  = 1'b1;
                    sram_addr = rd_ptr;
                    state_d   = ST_RD_WAIT;
                end else begin
                    wr_ready = init_q && not_full;
                end
            end
            ST_RD_WAIT: begin
                wr_ready = init_q && not_full;
                state_d  = ST_IDLE;
            end
        endcase
        push = wr_valid && wr_ready;
        if (push) begin
            sram_we   = 1'b1;
            sram_addr = wr_ptr;
            sram_din  = wr_data;
        end
    end

    // FSM state, pointers, occupancy and the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_vld   <= 1'b0;
            rd_data_q <= '0;
            init_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_issue) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push) begin
                mem_cnt <= mem_cnt + CNT_W'(1);
            end else if (rd_issue) begin
                mem_cnt <= mem_cnt - CNT_W'(1);
            end
            if (state_q == ST_RD_WAIT) begin
                rd_data_q <= sram_dout;
                out_vld   <= 1'b1;
            end else if (pop) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomized scoreboard bench for sram_fifo_ctrl.
// Includes a behavioural 256x8 sram with one-cycle read latency.
module tb_sram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [8:0] count;
    logic       sram_we;
    logic [7:0] sram_addr;
    logic [7:0] sram_din;
    logic [7:0] sram_dout;

    logic [7:0] mem [256];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_din;
        sram_dout <= mem[sram_addr];
    end

    sram_fifo_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .count     (count),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle; record an accepted push as an expected pop.
    task automatic step(input logic wv, input logic [7:0] wd,
                        input logic rr, output logic acc);
        @(negedge clk);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        #1;
        acc = wv && wr_ready;
        if (acc) exp_q.push_back(wd);
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) step(1'b0, 8'h00, 1'b0, a);
    endtask

    task automatic push_word(input logic [7:0] d, input logic rr);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 20 && !a; i++) step(1'b1, d, rr, a);
        if (!a) chk("push_timeout", 0, 1);
    endtask

    task automatic drain();
        logic a;
        bit   done;
        done = 1'b0;
        for (int i = 0; i < 1200 && !done; i++) begin
            step(1'b0, 8'h00, 1'b1, a);
            done = (exp_q.size() == 0) && (count == 0) && !rd_valid;
        end
        chk("drain_done", int'(done), 1);
        idle(1);
    endtask

    // Monitor: occupancy sanity each cycle, data order on every pop.
    initial begin
        int sz;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                sz = exp_q.size();
                checks++;
                if (!(int'(count) <= sz && int'(count) + 1 >= sz)) begin
                    errors++;
                    $display("FAIL count_range: got %0d model %0d", count, sz);
                end
                if (sz == 0) chk("empty_rd_valid", int'(rd_valid), 0);
            end
            #2;
            if (chk_en && rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", int'(rd_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", int'(rd_data), int'(e));
                end
            end
        end
    end

    initial begin
        logic a;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        rd_ready = 1'b0;
        #1;
        chk("rst_wr_ready", int'(wr_ready), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_sram_we", int'(sram_we), 0);
        chk("rst_sram_addr", int'(sram_addr), 0);
        chk("rst_sram_din", int'(sram_din), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("rel_wr_ready", int'(wr_ready), 1);
        chk("rel_rd_valid", int'(rd_valid), 0);
        chk("rel_count", int'(count), 0);
        chk_en = 1'b1;

        // Single word latency: write, read, capture.
        step(1'b1, 8'hF0, 1'b0, a);
        chk("single_acc", int'(a), 1);
        step(1'b0, 8'h00, 1'b0, a);
        chk("lat1_rd_valid", int'(rd_valid), 0);
        step(1'b0, 8'h00, 1'b0, a);
        chk("lat2_rd_valid", int'(rd_valid), 0);
        step(1'b0, 8'h00, 1'b0, a);
        chk("lat3_rd_valid", int'(rd_valid), 1);
        chk("lat3_rd_data", int'(rd_data), 8'hF0);
        chk("lat3_count", int'(count), 1);
        step(1'b0, 8'h00, 1'b1, a);
        step(1'b0, 8'h00, 1'b0, a);
        chk("pop_count", int'(count), 0);
        chk("pop_rd_valid", int'(rd_valid), 0);

        // Fill to capacity, then an extra push must be refused.
        for (int i = 0; i < 256; i++) push_word(8'(i), 1'b0);
        push_word(8'h55, 1'b0);
        idle(4);
        chk("full_count", int'(count), 257);
        chk("full_wr_ready", int'(wr_ready), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hAA, 1'b0, a);
            chk("extra_push", int'(a), 0);
        end
        drain();

        // Stream 300 words through so both pointers wrap.
        begin
            int n;
            n = 0;
            for (int i = 0; i < 3000 && n < 300; i++) begin
                step(1'b1, 8'($urandom), 1'b1, a);
                if (a) n++;
            end
            chk("wrap_pushed", n, 300);
        end
        drain();

        // Simultaneous push and pop.
        push_word(8'h10, 1'b0);
        idle(5);
        chk("sim1_count", int'(count), 1);
        step(1'b1, 8'h11, 1'b1, a);
        chk("sim1_acc", int'(a), 1);
        step(1'b0, 8'h00, 1'b0, a);
        chk("sim1_count_after", int'(count), 1);
        push_word(8'h12, 1'b0);
        push_word(8'h13, 1'b0);
        idle(5);
        chk("sim3_count", int'(count), 3);
        step(1'b1, 8'h14, 1'b1, a);
        chk("sim3_issue_ready", int'(a), 0);
        step(1'b1, 8'h14, 1'b0, a);
        chk("sim3_rdwait_ready", int'(a), 1);
        idle(5);
        chk("sim3_count_after", int'(count), 3);
        drain();

        // Reset while a capture is pending.
        step(1'b1, 8'h3C, 1'b0, a);
        step(1'b1, 8'h77, 1'b0, a);
        chk("mr_issue_ready", int'(a), 0);
        @(negedge clk);
        #1;
        chk("mr_rdwait_we", int'(sram_we), 1);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mr_rd_valid", int'(rd_valid), 0);
        chk("mr_count", int'(count), 0);
        chk("mr_sram_we", int'(sram_we), 0);
        chk("mr_wr_ready", int'(wr_ready), 0);
        wr_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("mr_rel_count", int'(count), 0);
        chk_en = 1'b1;
        push_word(8'hA5, 1'b0);
        push_word(8'h5A, 1'b0);
        drain();

        // Randomized mixed traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, (i / 400) % 2 ? 6 : 1) == 0, a);
        end
        drain();
        chk("final_model_empty", exp_q.size(), 0);
        chk("final_count", int'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
